// File: rtl/route_pkg.sv
// Shared definitions for the route arbiter and the output-side demux.
package route_pkg;

  localparam int unsigned DefaultDataW = 1536;
  localparam int unsigned NarrowW      = 128;

  typedef enum logic [0:0] {
    IDLE,
    XFER
  } route_state_t;

  // ceil(log2(n)) with a floor of one bit, so single-entry fields stay legal.
  function automatic int unsigned tid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/route_rr_pick.sv
// Rotating priority encoder: returns the first set req bit at or after ptr, wrapping.
module route_rr_pick
  import route_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = tid_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int unsigned     cand;
  logic [ID_W-1:0] cand_idx;

  always_comb begin
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Scan from the farthest offset inward so the nearest hit overwrites the rest.
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      cand     = (32'(ptr) + unsigned'(k)) % NUM_SRC;
      cand_idx = ID_W'(cand);
      if (req[cand_idx]) begin
        idx = cand_idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_rr_arbiter.sv
// Burst-granular round-robin arbiter feeding the wide side of the width converter.
module route_rr_arbiter
  import route_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ID_W      = tid_width(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]          s_axis_tvalid,
  input  logic [NUM_SRC-1:0]          s_axis_tlast,
  output logic [NUM_SRC-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [ID_W-1:0]             m_axis_tid,
  output logic                        busy
);

  localparam int unsigned BeatW = tid_width(BURST_LEN);

  if (NUM_SRC < 1 || NUM_SRC > 16) begin : gen_bad_num_src
    $error("route_rr_arbiter: NUM_SRC out of range");
  end
  if (BURST_LEN < 1 || BURST_LEN > 256) begin : gen_bad_burst_len
    $error("route_rr_arbiter: BURST_LEN out of range");
  end

  route_state_t     state_q, state_d;
  logic [ID_W-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [BeatW-1:0] beat_q, beat_d;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic              xfer;
  logic              hs;
  logic              last_beat;
  logic [ID_W-1:0]   ptr_wrap;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;

  route_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_pick (
    .req (s_axis_tvalid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Source mux on the registered grant; pure pass-through, no storage.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (gnt_q == ID_W'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  always_comb begin
    xfer          = (state_q == XFER);
    last_beat     = (beat_q == BeatW'(BURST_LEN - 1));
    m_axis_tdata  = xfer ? sel_data : '0;
    m_axis_tvalid = xfer & sel_valid;
    m_axis_tlast  = xfer & (sel_last | last_beat);
    m_axis_tid    = gnt_q;
    busy          = xfer;
    hs            = m_axis_tvalid & m_axis_tready;
    s_axis_tready = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      s_axis_tready[i] = xfer & (gnt_q == ID_W'(i)) & m_axis_tready;
    end
    ptr_wrap = (gnt_q == ID_W'(NUM_SRC - 1)) ? '0 : gnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        if (hs) begin
          beat_d = beat_q + 1'b1;
          // Source tlast and the length cap coincide into a single burst end.
          if (m_axis_tlast) begin
            state_d = IDLE;
            ptr_d   = ptr_wrap;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_route_rr_arbiter.sv
// Directed bench for route_rr_arbiter: framing, rotation, backpressure, stall, skip, reset.
module tb_route_rr_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned BL = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*DW-1:0] s_axis_tdata;
  logic [NS-1:0]   s_axis_tvalid;
  logic [NS-1:0]   s_axis_tlast;
  logic [NS-1:0]   s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [1:0]      m_axis_tid;
  logic            busy;

  int total = 0;
  int bad   = 0;

  route_rr_arbiter #(
    .NUM_SRC   (NS),
    .DATA_W    (DW),
    .BURST_LEN (BL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got hung want finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] word(input int src, input int b);
    return {32'(src) + 32'hA0, 32'(b)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < int'(NS); i++) s_axis_tdata[i*DW +: DW] = word(i, 32'hdead);
    step();
    rst = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    #2;
    check({tag, ".idle_valid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    check({tag, ".idle_ready"}, 64'(s_axis_tready), 64'd0);
    step();
  endtask

  // Beats first..first+count-1 of a src burst whose final beat index is burst_end.
  task automatic do_burst(input string tag, input int src, input int first, input int count,
                          input int burst_end, input bit src_last);
    for (int b = first; b < first + count; b++) begin
      s_axis_tdata[src*DW +: DW] = word(src, b);
      s_axis_tlast[src]          = src_last && (b == burst_end);
      #2;
      check({tag, ".valid"}, 64'(m_axis_tvalid), 64'd1);
      check({tag, ".tid"}, 64'(m_axis_tid), 64'(src));
      check({tag, ".data"}, m_axis_tdata, word(src, b));
      check({tag, ".last"}, 64'(m_axis_tlast), 64'(b == burst_end));
      check({tag, ".ready"}, 64'(s_axis_tready), m_axis_tready ? 64'(1 << src) : 64'd0);
      step();
    end
  endtask

  initial begin
    int b;

    // Reset state
    rst           = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    #3;
    check("rst.valid", 64'(m_axis_tvalid), 64'd0);
    check("rst.last", 64'(m_axis_tlast), 64'd0);
    check("rst.tid", 64'(m_axis_tid), 64'd0);
    check("rst.ready", 64'(s_axis_tready), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.data", m_axis_tdata, 64'd0);

    // Single source, 3-beat burst ended by tlast; then ptr=1 favours src1 over src0
    do_reset();
    s_axis_tvalid = 4'b0001;
    idle_cycle("t1");
    do_burst("t1", 0, 0, 3, 2, 1'b1);
    s_axis_tvalid = 4'b0011;
    idle_cycle("t1b");
    do_burst("t1b", 1, 0, 1, 0, 1'b1);

    // Full rotation with forced ends at BL
    do_reset();
    s_axis_tvalid = 4'b1111;
    idle_cycle("t2");
    for (int k = 0; k < 5; k++) begin
      do_burst("t2", k % 4, 0, int'(BL), int'(BL) - 1, 1'b0);
      idle_cycle("t2");
    end

    // Backpressure on a src2 burst
    do_reset();
    s_axis_tvalid = 4'b0100;
    idle_cycle("t3");
    b = 0;
    for (int t = 0; t < 64 && b < int'(BL); t++) begin
      m_axis_tready              = (t % 2 == 0);
      s_axis_tdata[2*DW +: DW]   = word(2, b);
      #2;
      check("t3.valid", 64'(m_axis_tvalid), 64'd1);
      check("t3.data", m_axis_tdata, word(2, b));
      check("t3.last", 64'(m_axis_tlast), 64'(b == int'(BL) - 1));
      check("t3.ready", 64'(s_axis_tready), m_axis_tready ? 64'b0100 : 64'd0);
      step();
      if (m_axis_tready) b++;
    end
    check("t3.count", 64'(b), 64'(BL));
    m_axis_tready = 1'b1;
    s_axis_tvalid = '0;
    idle_cycle("t3");

    // Source stall: src2 drops valid for 5 cycles while src1 requests
    do_reset();
    s_axis_tvalid = 4'b0100;
    idle_cycle("t4");
    do_burst("t4", 2, 0, 4, 15, 1'b0);
    s_axis_tvalid = 4'b0010;
    for (int t = 0; t < 5; t++) begin
      #2;
      check("t4.stall_valid", 64'(m_axis_tvalid), 64'd0);
      check("t4.stall_tid", 64'(m_axis_tid), 64'd2);
      check("t4.stall_busy", 64'(busy), 64'd1);
      check("t4.stall_ready", 64'(s_axis_tready), 64'b0100);
      step();
    end
    s_axis_tvalid = 4'b0110;
    do_burst("t4r", 2, 4, 12, 15, 1'b0);
    s_axis_tvalid = 4'b0010;
    idle_cycle("t4");
    do_burst("t4n", 1, 0, 1, 0, 1'b1);

    // Pointer skip: ptr=2 with src1 and src3 requesting
    do_reset();
    s_axis_tvalid = 4'b0010;
    idle_cycle("t5");
    do_burst("t5a", 1, 0, 1, 0, 1'b1);
    s_axis_tvalid = 4'b1010;
    idle_cycle("t5");
    do_burst("t5b", 3, 0, 1, 0, 1'b1);
    idle_cycle("t5");
    do_burst("t5c", 1, 0, 1, 0, 1'b1);

    // Reset asserted on beat 7, outputs must drop without a clock edge
    do_reset();
    s_axis_tvalid = 4'b1111;
    idle_cycle("t6");
    do_burst("t6", 0, 0, 7, 15, 1'b0);
    s_axis_tdata[0 +: DW] = word(0, 7);
    #2;
    check("t6.pre_valid", 64'(m_axis_tvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6.rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("t6.rst_ready", 64'(s_axis_tready), 64'd0);
    check("t6.rst_busy", 64'(busy), 64'd0);
    check("t6.rst_last", 64'(m_axis_tlast), 64'd0);
    check("t6.rst_data", m_axis_tdata, 64'd0);
    step();
    rst = 1'b0;
    idle_cycle("t6");
    do_burst("t6r", 0, 0, 1, 15, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
